// File: rtl/mips_debug_ctrl.sv
// Host-side debug/run controller for the five-stage MIPS pipeline.
// Decodes UART command bytes, gates the pipeline clock enable and streams an 8-byte PC/cycle status dump.
module mips_debug_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter logic [7:0]  CMD_RUN      = 8'h63,
    parameter logic [7:0]  CMD_STEP     = 8'h73,
    parameter logic [7:0]  CMD_RESET    = 8'h72,
    parameter logic [7:0]  CMD_DUMP     = 8'h70,
    parameter logic [7:0]  CMD_HALT     = 8'h68
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        halt,
    input  logic [31:0] pc,
    output logic        pipe_en,
    output logic        pipe_reset,
    output logic [31:0] cycle_count,
    output logic        halted
);

    localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RST        = 3'd0,
        S_IDLE       = 3'd1,
        S_RUN        = 3'd2,
        S_STEP       = 3'd3,
        S_SEND_ISSUE = 3'd4,
        S_SEND_WAIT  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic            halted_q, halted_d;
    logic [63:0]     shadow_q, shadow_d;
    logic [2:0]      idx_q, idx_d;
    logic            guard_q, guard_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            pipe_en_q, pipe_en_d;
    logic            pipe_reset_q, pipe_reset_d;
    logic            snap_s;

    // Byte i of the dump, most significant byte first.
    function automatic logic [7:0] dump_byte(input logic [63:0] sh, input logic [2:0] i);
        logic [63:0] t;
        t = sh << {i, 3'b000};
        return t[63:56];
    endfunction

    // Next-state, counter, snapshot and output decode.
    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        halted_d      = halted_q;
        idx_d         = idx_q;
        guard_d       = 1'b0;
        shadow_d      = shadow_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        snap_s        = 1'b0;

        case (state_q)
            S_RST: begin
                halted_d = 1'b0;
                if (rcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_RUN && !halted_q) begin
                        state_d = S_RUN;
                    end else if (rx_data == CMD_STEP && !halted_q) begin
                        state_d = S_STEP;
                    end else if (rx_data == CMD_RESET) begin
                        state_d = S_RST;
                    end else if (rx_data == CMD_DUMP) begin
                        state_d = S_SEND_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // A retiring HALT beats any byte arriving in the same cycle.
                if (halt) begin
                    halted_d = 1'b1;
                    state_d  = S_SEND_ISSUE;
                end else if (rx_valid && rx_data == CMD_HALT) begin
                    state_d = S_IDLE;
                end else if (rx_valid && rx_data == CMD_RESET) begin
                    state_d = S_RST;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (halt) begin
                    halted_d = 1'b1;
                end else begin
                    halted_d = halted_q;
                end
                state_d = S_SEND_ISSUE;
            end
            S_SEND_ISSUE: begin
                if (tx_start_q) begin
                    state_d = S_SEND_WAIT;
                    guard_d = 1'b1;
                end else begin
                    state_d = S_SEND_ISSUE;
                end
            end
            S_SEND_WAIT: begin
                if (guard_q || tx_busy) begin
                    state_d = S_SEND_WAIT;
                end else if (idx_q == 3'd7) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SEND_ISSUE;
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        if (state_d == S_RST && state_q != S_RST) begin
            rcnt_d = RST_LOAD;
        end else begin
            rcnt_d = rcnt_d;
        end

        if (state_q == S_RST) begin
            cycle_count_d = 32'd0;
        end else if (pipe_en_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end

        // The snapshot sees the count including the cycle that triggered the dump.
        if (state_d == S_SEND_ISSUE && state_q != S_SEND_ISSUE && state_q != S_SEND_WAIT) begin
            snap_s   = 1'b1;
            shadow_d = {pc, cycle_count_d};
            idx_d    = 3'd0;
        end else begin
            snap_s   = 1'b0;
        end

        if (state_d == S_SEND_ISSUE && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = dump_byte(shadow_d, idx_d);
        end else begin
            tx_start_d = 1'b0;
        end

        pipe_en_d    = (state_d == S_RUN) || (state_d == S_STEP);
        pipe_reset_d = (state_d == S_RST);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RST;
            rcnt_q        <= RST_LOAD;
            cycle_count_q <= 32'd0;
            halted_q      <= 1'b0;
            shadow_q      <= 64'd0;
            idx_q         <= 3'd0;
            guard_q       <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            pipe_en_q     <= 1'b0;
            pipe_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            guard_q       <= guard_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            pipe_en_q     <= pipe_en_d;
            pipe_reset_q  <= pipe_reset_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign pipe_en     = pipe_en_q;
    assign pipe_reset  = pipe_reset_q;
    assign cycle_count = cycle_count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Scoreboard bench for mips_debug_ctrl: expected dump bytes are queued when commands are sent
// and compared as the controller strobes them out through an emulated UART transmitter.
module tb_mips_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        halt;
    logic [31:0] pc;
    logic        pipe_en;
    logic        pipe_reset;
    logic [31:0] cycle_count;
    logic        halted;

    mips_debug_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .halt        (halt),
        .pc          (pc),
        .pipe_en     (pipe_en),
        .pipe_reset  (pipe_reset),
        .cycle_count (cycle_count),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          en_cnt = 0;
    int          stb_cnt = 0;
    int          busy_len = 3;
    int          busy_left = 0;
    logic [31:0] model_cnt;
    int          e0;
    int          s0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_dump(input logic [31:0] p, input logic [31:0] c);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[8*(3-i) +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*(3-i) +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_dump();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        while (tx_busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("dump_done", exp_q.size(), 0);
    endtask

    task automatic wait_rst(input int exp_len);
        int n = 0;
        while (pipe_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("rst_len", n, exp_len);
    endtask

    task automatic do_step(input logic [31:0] p);
        pc = p;
        model_cnt = model_cnt + 32'd1;
        push_dump(p, model_cnt);
        e0 = en_cnt;
        send_byte(8'h73);
        wait_dump();
        check("step_en", en_cnt - e0, 1);
        check("step_cnt", cycle_count, model_cnt);
    endtask

    // UART transmitter model and output monitor.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (pipe_en) en_cnt++;
            if (tx_start) begin
                stb_cnt++;
                check("busy_at_stb", tx_busy, 0);
                if (exp_q.size() == 0) begin
                    check("unexp_stb", tx_data, 64'hDEAD);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0; pc = 32'd0;
        model_cnt = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_pipe_reset", pipe_reset, 1);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_cnt", cycle_count, 0);
        check("rst_halted", halted, 0);
        reset = 1'b0;
        wait_rst(4);
        check("idle_pipe_en", pipe_en, 0);
        check("idle_cnt", cycle_count, 0);

        // Single steps with advancing PC.
        for (int i = 0; i < 3; i++) do_step(32'(4 * i));

        // Dump against a slow transmitter.
        busy_len = 20;
        pc = 32'h0040_1234;
        push_dump(pc, model_cnt);
        s0 = stb_cnt;
        send_byte(8'h70);
        wait_dump();
        check("dump_stb", stb_cnt - s0, 8);
        busy_len = 3;

        // Unknown byte is ignored.
        e0 = en_cnt;
        send_byte(8'h41);
        repeat (5) @(negedge clk);
        check("junk_en", en_cnt - e0, 0);

        // Counter wrap through two steps.
        @(negedge clk);
        dut.cycle_count_q = 32'hFFFF_FFFE;
        model_cnt = 32'hFFFF_FFFE;
        do_step(32'h0000_0010);
        do_step(32'h0000_0014);
        check("wrap_cnt", cycle_count, 0);

        send_byte(8'h72);
        wait_rst(4);
        model_cnt = 32'd0;
        check("r_cnt", cycle_count, 0);

        // Free run until HALT retires, with a colliding 'h' byte.
        pc = 32'h0000_0100;
        push_dump(pc, 32'd10);
        e0 = en_cnt;
        send_byte(8'h63);
        repeat (9) @(negedge clk);
        halt = 1'b1; rx_valid = 1'b1; rx_data = 8'h68;
        @(negedge clk);
        halt = 1'b0; rx_valid = 1'b0;
        wait_dump();
        check("run_en", en_cnt - e0, 10);
        check("run_halted", halted, 1);
        check("run_cnt", cycle_count, 10);

        // Run and step are blocked while halted.
        e0 = en_cnt;
        send_byte(8'h63);
        send_byte(8'h73);
        repeat (5) @(negedge clk);
        check("blocked_en", en_cnt - e0, 0);
        check("blocked_halted", halted, 1);

        send_byte(8'h72);
        wait_rst(4);
        check("r2_halted", halted, 0);
        check("r2_cnt", cycle_count, 0);

        // Host halt command ends a free run without a dump.
        e0 = en_cnt;
        send_byte(8'h63);
        repeat (4) @(negedge clk);
        send_byte(8'h68);
        repeat (5) @(negedge clk);
        check("hcmd_en", en_cnt - e0, 6);
        check("hcmd_cnt", cycle_count, 6);
        check("hcmd_halted", halted, 0);
        check("hcmd_pipe_en", pipe_en, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_debug_ctrl.md
# mips_debug_ctrl

Debug/run controller that sequences the five-stage MIPS pipeline from the host UART link. It decodes single-byte commands from the UART receiver and gates the pipeline with a clock enable: free-run, single-step and pipeline reset. It also returns an 8-byte status dump (PC, cycle count) through the UART transmitter. It sits between the UART rx/tx blocks and the top-level datapath latches (PC, IF_ID, ID_EX, EX_MEM, MEM_WB, register file).

## Interface
Parameters:
- RESET_CYCLES, 4: cycles `pipe_reset` stays high after entering RST (≥1).
- CMD_RUN, 8'h63: 'c', free-run until HALT retires.
- CMD_STEP, 8'h73: 's', advance the pipeline exactly one clock.
- CMD_RESET, 8'h72: 'r', reset the pipeline and clear the counter.
- CMD_DUMP, 8'h70: 'p', send the status dump.
- CMD_HALT, 8'h68: 'h', stop a free-run.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  received byte, valid while `rx_valid`.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_busy  in  1  transmitter busy; rises the cycle after `tx_start`.
- tx_start  out  1  one-cycle strobe to send `tx_data`.
- tx_data  out  8  byte to transmit; held from issue until the next issue.
- halt  in  1  HALT instruction retired in WB this cycle.
- pc  in  32  current fetch PC.
- pipe_en  out  1  enable to PC and all pipeline latches.
- pipe_reset  out  1  synchronous clear to PC, latches and register file.
- cycle_count  out  32  number of cycles with `pipe_en`=1.
- halted  out  1  sticky: a HALT has retired since the last pipeline reset.

## Operation
- FSM states: RST, IDLE, RUN, STEP, SEND_ISSUE, SEND_WAIT.
- Decode from the registered state:
  - `pipe_en` = (RUN or STEP).
  - `pipe_reset` = RST.
  - `tx_start` = SEND_ISSUE.
- RST:
  - `cycle_count` and `halted` are cleared.
  - A down-counter loaded with RESET_CYCLES-1 runs to 0, then the FSM goes to IDLE.
  - `rx_valid` is ignored.
- IDLE, on `rx_valid`:
  - CMD_RUN goes to RUN, only if `halted`=0.
  - CMD_STEP goes to STEP, only if `halted`=0.
  - CMD_RESET goes to RST.
  - CMD_DUMP goes to SEND_ISSUE.
  - Any other byte, or a blocked RUN/STEP, leaves the FSM in IDLE with no response.
- RUN, priority order:
  - `halt`=1: set `halted`, go to SEND_ISSUE (auto-dump).
  - `rx_valid` with CMD_HALT: go to IDLE.
  - `rx_valid` with CMD_RESET: go to RST.
  - Other bytes are ignored.
- STEP:
  - Exactly one cycle.
  - If `halt`=1 that cycle, set `halted`.
  - Always go to SEND_ISSUE.
- Dump snapshot: on every entry to SEND_ISSUE from a non-SEND state, capture `pc` and the post-update `cycle_count` into a 64-bit shadow register. Reset the byte index to 0.
- Dump byte order: PC[31:24], PC[23:16], PC[15:8], PC[7:0], then CNT[31:24], CNT[23:16], CNT[15:8], CNT[7:0].
- SEND_ISSUE:
  - Entered only when `tx_busy`=0; if `tx_busy`=1, stay without strobing.
  - When the strobe fires, `tx_data` = shadow byte[index]; go to SEND_WAIT.
- SEND_WAIT:
  - The first cycle is a guard cycle and ignores `tx_busy`.
  - Afterwards, wait for `tx_busy`=0.
  - Then, if index=7, go to IDLE; otherwise increment the index and go to SEND_ISSUE.
- `rx_valid` is ignored in SEND_* states and in STEP.
- `cycle_count`:
  - Increments by 1 on each clock with `pipe_en`=1.
  - Wraps from 32'hFFFFFFFF to 0.
  - RST has priority over increment.
- `halted` stays set across IDLE and dumps; only RST clears it.

## Timing
- Values while `reset` is asserted:
  - FSM state is RST, so `pipe_reset`=1.
  - `pipe_en`=0, `tx_start`=0.
  - `tx_data`=8'h00, `cycle_count`=0, `halted`=0.
- After `reset` deasserts, `pipe_reset` stays high exactly RESET_CYCLES more clocks, then IDLE.
- Command latency: a byte strobed at edge N changes the state at edge N+1.
  - `pipe_en` is high from cycle N+1.
  - STEP gives exactly one cycle of `pipe_en`.
- RUN exit on `halt` at edge H: `pipe_en` was 1 in cycle H and is 0 from cycle H+1. That cycle is counted.
- Per dump byte: a minimum of 2 cycles plus the transmitter busy time.
- Asserting `reset` in mid-dump or mid-run aborts immediately (asynchronous). No partial-byte recovery.
- Simultaneous `halt` and `rx_valid` in RUN: `halt` wins and the byte is dropped.

## Test plan
- Reset release: hold `reset` 3 cycles, then release. Expect `pipe_reset`=1 for exactly 4 cycles after release, then IDLE with `pipe_en`=0 and `cycle_count`=0.
- Step: send 's' 3 times with `pc` stepping 0→4→8. Expect 3 single-cycle `pipe_en` pulses and 3 dumps. The last dump is 00 00 00 08 00 00 00 03 (with `pc`=8 at capture).
- Run to halt: send 'c', assert `halt` after 10 enabled cycles. Expect `pipe_en` for 10 cycles, `halted`=1, and an auto-dump whose CNT bytes are 00 00 00 0A. Then send 'c' and expect no `pipe_en`.
- Halt command: send 'c', then 'h' 5 cycles later. Expect the FSM back in IDLE, `halted`=0, and `cycle_count`=6.
- Busy handshake: hold `tx_busy`=1 for 20 cycles after each strobe during a 'p' dump. Expect exactly 8 `tx_start` pulses, none while `tx_busy`=1, bytes in MSB-first order.
- Counter wrap and reset: force `cycle_count` to FFFFFFFE, then step twice. Expect 00000000; then 'r' keeps it at 0 and clears `halted`.
